// File: rtl/uc_arbiter_if.sv
// Bundle of the engine-side handshake and the ucq broadcast bus of uc_arbiter.
// master: the arbiter itself. slave: engines plus unit clause queues.
interface uc_arbiter_if #(
  parameter int NUM_ENG = 4,
  parameter int NUM_UCQ = 4,
  parameter int LIT_W   = 11
);
  localparam int GID_W = $clog2(NUM_ENG);

  logic [NUM_ENG-1:0]            eng_valid;
  logic [NUM_ENG-1:0][LIT_W-1:0] eng_lit;
  logic [NUM_ENG-1:0]            eng_ready;
  logic [NUM_UCQ-1:0]            ucq_full;
  logic [NUM_UCQ-1:0]            ucq_push;
  logic [LIT_W-1:0]              uca2ucq;
  logic [GID_W-1:0]              grant_id;
  logic                          busy;
  logic                          conflict;

  modport master (
    input  eng_valid, eng_lit, ucq_full,
    output eng_ready, ucq_push, uca2ucq, grant_id, busy, conflict
  );

  modport slave (
    output eng_valid, eng_lit, ucq_full,
    input  eng_ready, ucq_push, uca2ucq, grant_id, busy, conflict
  );
endinterface

// File: rtl/uc_arbiter.sv
// uc_arbiter: round-robin collector of unit-clause literals from NUM_ENG engines,
// serialised one per cycle through a one-entry holding register and broadcast
// to NUM_UCQ unit clause queues (all pushed together or none).
// Optional feature macro: UCA_DEDUP_EN -- history filter that drops duplicate
// literals and flags complementary ones on the sticky conflict output.
module uc_arbiter #(
  parameter int NUM_ENG     = 4,
  parameter int NUM_UCQ     = 4,
  parameter int UC_LENGTH   = 1024,
  parameter int DEDUP_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  uc_arbiter_if.master  bus
);
  localparam int LIT_W = $clog2(UC_LENGTH) + 1;
  localparam int VAR_W = LIT_W - 1;
  localparam int GID_W = $clog2(NUM_ENG);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [LIT_W-1:0] hold_lit_p1;
  logic [GID_W-1:0] rr_ptr;

  logic             flush;
  logic             hold_vld_p1;
  logic             push_fire;
  logic             can_acc;
  logic [GID_W:0]   pick;
  logic             grant_vld;
  logic [GID_W-1:0] grant_idx;
  logic             accept;
  logic             load;
  logic [LIT_W-1:0] acc_lit;
  logic             drop_dup;
  logic             drop_opp;

  // First valid engine at or after ptr, wrapping; MSB of the result flags "found".
  function automatic logic [GID_W:0] rr_pick(input logic [NUM_ENG-1:0] valid,
                                             input logic [GID_W-1:0]   ptr);
    logic [GID_W:0]   res;
    logic [GID_W:0]   sum;
    logic [GID_W-1:0] idx;
    res = '0;
    // Walk from the farthest offset down so the nearest valid engine wins.
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (GID_W + 1)'(k);
      if (sum >= (GID_W + 1)'(NUM_ENG)) sum = sum - (GID_W + 1)'(NUM_ENG);
      idx = sum[GID_W-1:0];
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Successor engine index modulo NUM_ENG (NUM_ENG need not be a power of two).
  function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] idx);
    return (idx == GID_W'(NUM_ENG - 1)) ? '0 : idx + GID_W'(1);
  endfunction

  assign flush       = rst | clear;
  assign hold_vld_p1 = (state_q == S_HOLD);
  assign push_fire   = hold_vld_p1 & ~|bus.ucq_full & ~flush;
  assign can_acc     = ~hold_vld_p1 | push_fire;
  assign pick        = rr_pick(bus.eng_valid, rr_ptr);
  assign grant_vld   = pick[GID_W];
  assign grant_idx   = pick[GID_W-1:0];
  assign accept      = grant_vld & can_acc & ~flush;
  assign acc_lit     = bus.eng_lit[grant_idx];
  assign load        = accept & ~drop_dup & ~drop_opp;

  assign bus.uca2ucq  = hold_lit_p1;
  assign bus.grant_id = grant_idx;
  assign bus.busy     = hold_vld_p1;

`ifdef UCA_DEDUP_EN
  localparam int HIST_W = (DEDUP_DEPTH > 1) ? $clog2(DEDUP_DEPTH) : 1;

  logic [LIT_W-1:0]       hist_lit [DEDUP_DEPTH];
  logic [DEDUP_DEPTH-1:0] hist_vld;
  logic [HIST_W-1:0]      hist_wr;
  logic                   conflict_q;

  // Compare the granted literal against every valid history entry.
  always_comb begin
    drop_dup = 1'b0;
    drop_opp = 1'b0;
    for (int k = 0; k < DEDUP_DEPTH; k++) begin
      if (hist_vld[k] && (hist_lit[k][VAR_W-1:0] == acc_lit[VAR_W-1:0])) begin
        if (hist_lit[k][VAR_W] == acc_lit[VAR_W]) drop_dup = 1'b1;
        else                                      drop_opp = 1'b1;
      end
    end
  end

  // History FIFO: only literals that are actually loaded are recorded.
  always_ff @(posedge clk) begin
    if (flush) begin
      hist_vld <= '0;
      hist_wr  <= '0;
    end else if (load) begin
      hist_lit[hist_wr] <= acc_lit;
      hist_vld[hist_wr] <= 1'b1;
      hist_wr           <= (hist_wr == HIST_W'(DEDUP_DEPTH - 1)) ? '0 : hist_wr + HIST_W'(1);
    end
  end

  // Sticky conflict flag, raised by a complementary (not duplicate) accept.
  always_ff @(posedge clk) begin
    if (flush) begin
      conflict_q <= 1'b0;
    end else if (accept && drop_opp && !drop_dup) begin
      conflict_q <= 1'b1;
    end
  end

  assign bus.conflict = conflict_q;
`else
  logic unused_dedup_depth;

  assign unused_dedup_depth = (DEDUP_DEPTH > 0);
  assign drop_dup           = 1'b0;
  assign drop_opp           = 1'b0;
  assign bus.conflict       = 1'b0;
`endif

  // State register: IDLE when the holding register is empty, HOLD otherwise.
  always_ff @(posedge clk) begin
    if (flush) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus handshake outputs (one-hot ready, all-or-none push).
  always_comb begin
    state_d       = state_q;
    bus.eng_ready = '0;
    bus.ucq_push  = {NUM_UCQ{push_fire}};
    if (accept) bus.eng_ready[grant_idx] = 1'b1;
    case (state_q)
      S_IDLE: if (load) state_d = S_HOLD;
      S_HOLD: if (push_fire && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p1: holding register loaded with the accepted literal.
  always_ff @(posedge clk) begin
    if (flush)     hold_lit_p1 <= '0;
    else if (load) hold_lit_p1 <= acc_lit;
  end

  // Round-robin pointer moves past the engine just served, even if its literal was dropped.
  always_ff @(posedge clk) begin
    if (flush)       rr_ptr <= '0;
    else if (accept) rr_ptr <= next_ptr(grant_idx);
  end
endmodule

// File: tb/tb_uc_arbiter.sv
// Randomised and directed bench for uc_arbiter against a behavioural model.
// Define UCA_DEDUP_EN for both bench and RTL to exercise the history filter.
module tb_uc_arbiter;
  localparam int NUM_ENG     = 4;
  localparam int NUM_UCQ     = 4;
  localparam int UC_LENGTH   = 1024;
  localparam int DEDUP_DEPTH = 8;
  localparam int LIT_W       = $clog2(UC_LENGTH) + 1;
  localparam int VAR_MASK    = (1 << (LIT_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  uc_arbiter_if #(.NUM_ENG(NUM_ENG), .NUM_UCQ(NUM_UCQ), .LIT_W(LIT_W)) bus ();

  uc_arbiter #(
    .NUM_ENG(NUM_ENG), .NUM_UCQ(NUM_UCQ), .UC_LENGTH(UC_LENGTH), .DEDUP_DEPTH(DEDUP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: held literal (-1 = empty), next engine to favour, conflict flag, history.
  int m_hold;
  int m_rr;
  bit m_conf;
  int m_hist[$];
  int pushed[$];

  bit [NUM_ENG-1:0] v;
  int               lit [NUM_ENG];
  bit [NUM_UCQ-1:0] full;
  bit [NUM_ENG-1:0] last_er;
  int               last_gid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_hold = -1;
    m_rr   = 0;
    m_conf = 1'b0;
    m_hist.delete();
  endtask

  task automatic apply();
    bus.eng_valid = v;
    for (int i = 0; i < NUM_ENG; i++) bus.eng_lit[i] = LIT_W'(lit[i]);
    bus.ucq_full = full;
  endtask

  function automatic int rand_lit();
    return int'(($urandom_range(1, 0) << (LIT_W - 1)) | $urandom_range(15, 0));
  endfunction

  // One clock: check DUT against the model at negedge, then advance the model.
  task automatic step();
    int               g;
    int               nhold;
    bit               pf, ca, acc, dup, opp;
    bit [NUM_ENG-1:0] er;
    bit [NUM_UCQ-1:0] ep;
    apply();
    @(negedge clk);
    er = '0; pf = 1'b0; acc = 1'b0; g = -1; nhold = m_hold;
    if (!(rst || clear)) begin
      pf = (m_hold >= 0) && (full == '0);
      ca = (m_hold < 0) || pf;
      for (int k = 0; k < NUM_ENG; k++) begin
        int e;
        e = (m_rr + k) % NUM_ENG;
        if (g < 0 && v[e]) g = e;
      end
      acc = ca && (g >= 0);
      if (acc) er[g] = 1'b1;
    end
    ep = pf ? '1 : '0;
    chk("eng_ready", 32'(bus.eng_ready), 32'(er));
    chk("ucq_push", 32'(bus.ucq_push), 32'(ep));
    chk("busy", 32'(bus.busy), 32'(m_hold >= 0));
    chk("conflict", 32'(bus.conflict), 32'(m_conf));
    if (m_hold >= 0) chk("uca2ucq", 32'(bus.uca2ucq), m_hold);
    if (acc) chk("grant_id", 32'(bus.grant_id), g);
    if (pf) begin
      pushed.push_back(m_hold);
      nhold = -1;
    end
    if (rst || clear) begin
      model_reset();
      nhold = -1;
    end else if (acc) begin
      m_rr = (g + 1) % NUM_ENG;
      dup = 1'b0;
      opp = 1'b0;
`ifdef UCA_DEDUP_EN
      foreach (m_hist[j]) begin
        if ((m_hist[j] & VAR_MASK) == (lit[g] & VAR_MASK)) begin
          if (m_hist[j] == lit[g]) dup = 1'b1;
          else                     opp = 1'b1;
        end
      end
      if (!dup && opp) m_conf = 1'b1;
      if (!dup && !opp) begin
        m_hist.push_back(lit[g]);
        if (m_hist.size() > DEDUP_DEPTH) void'(m_hist.pop_front());
      end
`endif
      if (!dup && !opp) nhold = lit[g];
    end
    m_hold = nhold;
    @(posedge clk);
    #1;
    last_er  = er;
    last_gid = g;
  endtask

  // Engines that were served drop valid; idle engines may raise a new literal.
  task automatic refill(input int p_valid);
    for (int i = 0; i < NUM_ENG; i++) begin
      if (last_er[i]) v[i] = 1'b0;
      if (!v[i] && $urandom_range(99, 0) < p_valid) begin
        v[i]   = 1'b1;
        lit[i] = rand_lit();
      end
    end
  endtask

  function automatic int count_pushed(input int val);
    int n;
    n = 0;
    foreach (pushed[j]) if (pushed[j] == val) n++;
    return n;
  endfunction

  initial begin
    int base;
    rst = 1'b1; clear = 1'b0; v = '1; full = '0;
    for (int i = 0; i < NUM_ENG; i++) lit[i] = i;
    model_reset();
    last_er = '0; last_gid = -1;
    apply();
    repeat (2) @(posedge clk);
    #1;

    // Reset with every engine requesting.
    step();
    chk("rst_uca2ucq", 32'(bus.uca2ucq), 0);
    rst = 1'b0;

    // Round robin with all engines requesting and empty queues.
    for (int i = 0; i < NUM_ENG; i++) lit[i] = 'h20 + i;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_order", last_gid, c % NUM_ENG);
      for (int i = 0; i < NUM_ENG; i++) if (last_er[i]) lit[i] = lit[i] + NUM_ENG;
    end

    // Back-pressure from one full queue, then release.
    full = 4'b0100;
    repeat (3) step();
    full = '0;
    base = pushed.size();
    step();
    chk("bp_release_push", pushed.size() - base, 1);
    chk("bp_release_acc", 32'(|last_er), 1);
    for (int i = 0; i < NUM_ENG; i++) if (last_er[i]) lit[i] = lit[i] + NUM_ENG;

    // Single requester on engine 2.
    clear = 1'b1; step(); clear = 1'b0;
    v = 4'b0100; lit[2] = 'h005;
    step();
    chk("single_gid", last_gid, 2);
    v = '0;
    step();
    chk("single_push", pushed[pushed.size() - 1], 'h005);
    v = '1;
    for (int i = 0; i < NUM_ENG; i++) lit[i] = 'h40 + i;
    step();
    chk("rr_after_single", last_gid, 3);

    // Clear during a stall discards the held literal.
    clear = 1'b1; step(); clear = 1'b0;
    v = 4'b0001; lit[0] = 'h00A; full = '1;
    step();
    v = '0;
    step();
    clear = 1'b1; step(); clear = 1'b0;
    full = '0;
    step();
    chk("clear_busy", 32'(bus.busy), 0);
    chk("clear_no_push", count_pushed('h00A), 0);
    v = '1;
    for (int i = 0; i < NUM_ENG; i++) lit[i] = 'h50 + i;
    step();
    chk("rr_after_clear", last_gid, 0);

`ifdef UCA_DEDUP_EN
    // Duplicate is swallowed; complement raises a sticky conflict.
    clear = 1'b1; v = '0; step(); clear = 1'b0;
    base = count_pushed('h003);
    v = 4'b0001; lit[0] = 'h003; step();
    v = 4'b0010; lit[1] = 'h003; step();
    v = '0; repeat (2) step();
    v = 4'b0100; lit[2] = 'h403; step();
    v = '0; repeat (2) step();
    chk("dedup_one_push", count_pushed('h003) - base, 1);
    chk("conflict_no_push", count_pushed('h403), 0);
    chk("conflict_set", 32'(bus.conflict), 1);
    clear = 1'b1; step(); clear = 1'b0;
    step();
    chk("conflict_cleared", 32'(bus.conflict), 0);
`endif

    // Random traffic with occasional clear/reset and back-pressure.
    v = '0;
    last_er = '0;
    for (int c = 0; c < 3000; c++) begin
      clear = ($urandom_range(99, 0) < 2);
      rst   = ($urandom_range(199, 0) < 1);
      full  = ($urandom_range(99, 0) < 30) ? NUM_UCQ'($urandom) : '0;
      refill(60);
      step();
    end
    rst = 1'b0; clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
